// File: rtl/crc_pkg.sv
// Shared types and constants for the serial CRC encoder.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2
    } crc_state_e;

    // g = x^4 + x^2 + x + 1, implicit x^4 term dropped
    localparam logic [3:0] CRC_POLY_DEFAULT = 4'b0111;

endpackage

// File: rtl/crc_lfsr.sv
// Single-bit CRC update step: fb = bit ^ msb; crc' = (crc << 1) ^ (fb ? POLY : 0).
module crc_lfsr
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W = 4,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC_POLY_DEFAULT)
) (
    input  logic [CRC_W-1:0] i_crc,
    input  logic             i_bit,
    output logic [CRC_W-1:0] o_crc
);

    logic fb;

    always_comb begin
        fb    = i_bit ^ i_crc[CRC_W-1];
        o_crc = {i_crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

endmodule

// File: rtl/crc_serial_enc.sv
// Serial CRC encoder: passes DATA_LEN message bits through, then appends the CRC MSB first.
// Define CRC_INIT_ONES_EN to preload the CRC register with all-ones instead of all-zeros.
module crc_serial_enc
    import crc_pkg::*;
#(
    parameter int unsigned      DATA_LEN = 8,
    parameter int unsigned      CRC_W    = 4,
    parameter logic [CRC_W-1:0] POLY     = CRC_W'(CRC_POLY_DEFAULT)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_data,
    output logic             o_busy,
    output logic             o_data,
    output logic             o_data_valid,
    output logic [CRC_W-1:0] o_crc,
    output logic             o_crc_done
);

    localparam int unsigned CNT_MAX = (DATA_LEN > CRC_W) ? DATA_LEN : CRC_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    // DATA only sees bits 1..DATA_LEN-1; bit 0 is taken in the start cycle
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'((DATA_LEN > 1) ? DATA_LEN - 2 : 0);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

`ifdef CRC_INIT_ONES_EN
    localparam logic [CRC_W-1:0] CRC_INIT = '1;
`else
    localparam logic [CRC_W-1:0] CRC_INIT = '0;
`endif

    crc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] crc_out_q, crc_out_d;
    logic             data_q, data_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [CRC_W-1:0] lfsr_in, lfsr_out;
    logic             crc_bit;

    assign lfsr_in = (state_q == ST_IDLE) ? CRC_INIT : crc_q;

    crc_lfsr #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_lfsr (
        .i_crc (lfsr_in),
        .i_bit (i_data),
        .o_crc (lfsr_out)
    );

    always_comb begin
        crc_bit = 1'b0;
        for (int unsigned i = 0; i < CRC_W; i++) begin
            if (cnt_q == CNT_W'(CRC_W - 1 - i)) crc_bit = crc_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        data_d    = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    crc_d   = lfsr_out;
                    data_d  = i_data;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = (DATA_LEN == 1) ? ST_CRC : ST_DATA;
                end
            end
            ST_DATA: begin
                crc_d   = lfsr_out;
                data_d  = i_data;
                valid_d = 1'b1;
                if (cnt_q == DATA_LAST) begin
                    state_d = ST_CRC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CRC: begin
                data_d  = crc_bit;
                valid_d = 1'b1;
                if (cnt_q == CRC_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    crc_out_d = crc_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            crc_q     <= CRC_INIT;
            crc_out_q <= '0;
            data_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign o_busy       = (state_q != ST_IDLE);
    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_crc        = crc_out_q;
    assign o_crc_done   = done_q;

endmodule

// File: doc/crc_serial_enc.md
CRC_SERIAL_ENC -- requirements
Module: crc_serial_enc

Interface
REQ-001 The module SHALL have parameter DATA_LEN, default 8, giving the message length in bits per frame (range 1..255).
REQ-002 The module SHALL have parameter CRC_W, default 4, giving the CRC width in bits (range 2..32).
REQ-003 The module SHALL have parameter POLY, default 4'b0111, giving the generator polynomial without its implicit x^CRC_W term (default g = x^4+x^2+x+1).
REQ-004 The module SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port i_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port i_start, input, 1 bit: frame start, sampled only in IDLE.
REQ-007 The module SHALL have port i_data, input, 1 bit: serial message bit, MSB first.
REQ-008 The module SHALL have port o_busy, output, 1 bit: high while in DATA or CRC state.
REQ-009 The module SHALL have port o_data, output, 1 bit: serial codeword (message bits, then CRC bits MSB first).
REQ-010 The module SHALL have port o_data_valid, output, 1 bit: qualifies o_data.
REQ-011 The module SHALL have port o_crc, output, CRC_W bits: parallel CRC of the last completed frame, held until the next frame completes.
REQ-012 The module SHALL have port o_crc_done, output, 1 bit: one-cycle pulse coincident with the last CRC bit on o_data.

Function
REQ-013 The FSM SHALL have states IDLE, DATA and CRC.
- IDLE->DATA on i_start.
- DATA->CRC after DATA_LEN bits.
- CRC->IDLE after CRC_W bits.
REQ-014 Cycle 0 is the cycle i_start=1 in IDLE; message bit k SHALL be sampled in cycle k, for k=0..DATA_LEN-1.
REQ-015 Per sampled bit, the CRC register SHALL update as: fb = i_data ^ crc[CRC_W-1]; crc <= (crc<<1) ^ (fb ? POLY : 0).
REQ-016 o_data SHALL be registered, so message bit k appears in cycle k+1 (latency 1).
REQ-017 CRC bit j (MSB first) SHALL appear in cycle DATA_LEN+1+j, for j=0..CRC_W-1.
REQ-018 o_data_valid SHALL be high exactly in cycles 1..DATA_LEN+CRC_W.
REQ-019 In cycle DATA_LEN+CRC_W, o_crc_done SHALL pulse and o_crc SHALL show the new CRC.
REQ-020 The FSM SHALL enter IDLE on the same edge that emits the last CRC bit, so an i_start in the o_crc_done cycle starts the next frame gaplessly.
REQ-021 i_start SHALL be ignored while o_busy=1.
REQ-022 i_data SHALL be ignored outside DATA and the start cycle.
REQ-023 Bit counters SHALL be $clog2-sized and SHALL clear on every state exit; they SHALL never wrap within a frame.
REQ-024 When o_data_valid=0, o_data SHALL be 0.

Reset
REQ-025 On i_reset_n=0, at any time including mid-frame, the block SHALL immediately take the following values:
- state=IDLE;
- counters=0;
- CRC register=init value;
- o_data=0, o_data_valid=0, o_crc_done=0, o_busy=0, o_crc=0.
REQ-026 A frame interrupted by reset SHALL be discarded, with no o_crc_done.

Configuration
REQ-027 With CRC_INIT_ONES_EN defined, the CRC register SHALL preload all-ones at each frame start and at reset; without it, the preload SHALL be all-zeros.
REQ-028 The macro SHALL NOT affect timing or ports.

Structure
REQ-029 Package crc_pkg SHALL hold the state enum type and the default polynomial constant.
REQ-030 Sub-module crc_lfsr (single-bit update step, parameterised by CRC_W/POLY) SHALL be the one natural sub-module, instantiated once.

Verification
REQ-031 The bench SHALL cover these directed scenarios, with defaults and the macro off unless stated:
- Message 8'h01 -> o_data = 0000_0001 then 0111; o_crc=4'b0111; o_crc_done in cycle 12.
- Message 8'h81 -> CRC 4'b0000; message 8'h80 -> CRC 4'b0111.
- Macro on, message 8'h00 -> CRC 4'b1001.
- Back-to-back: second i_start in the o_crc_done cycle -> second frame's first o_data bit in the following cycle, no gap.
- i_start pulses while busy -> ignored; reset asserted in cycle 5 -> all outputs 0 at once, no o_crc_done, next frame correct.
- CRC_W=8, POLY=8'h07, DATA_LEN=16 -> o_crc matches reference model for 200 random frames.
